// File: rtl/verdict_pkg.sv
// Shared types and constants for the verdict scheduler.
package verdict_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ISSUE  = 2'd1,
    IN_PKT = 2'd2
  } state_t;

  localparam logic VERDICT_MATCH    = 1'b0;
  localparam logic VERDICT_MISMATCH = 1'b1;

endpackage

// File: rtl/verdict_fifo.sv
// 1-bit-wide synchronous FIFO holding verdicts that run ahead of the data stream.
// Pointers carry one extra wrap bit so full and empty are distinguished without a counter.
module verdict_fifo #(
  parameter int DEPTH = 4
) (
  input  logic clock,
  input  logic reset,
  input  logic push,
  input  logic push_data,
  input  logic pop,
  output logic pop_data,
  output logic full,
  output logic empty
);

  localparam int ADDR_W = $clog2(DEPTH);

  logic [DEPTH-1:0] mem;
  logic [ADDR_W:0]  wr_ptr;
  logic [ADDR_W:0]  rd_ptr;
  logic             push_en;
  logic             pop_en;

  assign push_en  = push && !full;
  assign pop_en   = pop && !empty;
  assign empty    = (wr_ptr == rd_ptr);
  assign full     = (wr_ptr[ADDR_W] != rd_ptr[ADDR_W]) &&
                    (wr_ptr[ADDR_W-1:0] == rd_ptr[ADDR_W-1:0]);
  assign pop_data = mem[rd_ptr[ADDR_W-1:0]];

  // Read/write pointers; only these are reset, storage contents are don't-care when empty.
  always_ff @(posedge clock) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (push_en) wr_ptr <= wr_ptr + 1'b1;
      if (pop_en)  rd_ptr <= rd_ptr + 1'b1;
    end
  end

  // Verdict storage.
  always_ff @(posedge clock) begin
    if (push_en) mem[wr_ptr[ADDR_W-1:0]] <= push_data;
  end

endmodule

// File: rtl/verdict_scheduler.sv
// Releases one buffered comparator verdict per packet to the pass/zero gate,
// tracks the packet by snooping the gate's input beats, and keeps statistics.
module verdict_scheduler
  import verdict_pkg::*;
#(
  parameter int DEPTH          = 4,
  parameter int COUNT_W        = 32,
  parameter int TIMEOUT_CYCLES = 4096
) (
  input  logic               clock,
  input  logic               reset,
  input  logic               verdict_result,
  input  logic               verdict_valid,
  output logic               verdict_ready,
  output logic               gate_cmp_result,
  output logic               gate_cmp_valid,
  input  logic               gate_cmp_ready,
  input  logic               mon_valid,
  input  logic               mon_ready,
  input  logic               mon_last,
  input  logic               clear_stats,
  output logic [COUNT_W-1:0] stat_pass,
  output logic [COUNT_W-1:0] stat_fail,
  output logic               err_orphan,
  output logic               err_timeout,
  output logic               busy
);

  // Timer only needs to reach TIMEOUT_CYCLES-1; a zero limit disables it.
  localparam int                TIMER_W    = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam bit                TIMEOUT_EN = (TIMEOUT_CYCLES > 0);
  localparam logic [TIMER_W-1:0] TIMER_LAST = TIMER_W'((TIMEOUT_CYCLES > 0) ? TIMEOUT_CYCLES - 1 : 0);

  state_t             state;
  state_t             state_next;
  logic               held_verdict;
  logic               pkt_verdict;
  logic [TIMER_W-1:0] timer;
  logic               ready_armed;
  logic               fifo_full;
  logic               fifo_empty;
  logic               fifo_head;
  logic               fifo_pop;
  logic               verdict_push;
  logic               load_held;
  logic               beat_hs;
  logic               last_hs;
  logic               pkt_done;
  logic               pkt_timeout;

  function automatic logic [COUNT_W-1:0] sat_inc(input logic [COUNT_W-1:0] value);
    return (&value) ? value : value + 1'b1;
  endfunction

  // verdict_ready stays low through reset and rises on the first clock after it.
  assign verdict_ready   = ready_armed && !fifo_full;
  assign verdict_push    = verdict_valid && verdict_ready;
  assign beat_hs         = mon_valid && mon_ready;
  assign last_hs         = beat_hs && mon_last;
  assign gate_cmp_valid  = (state == ISSUE);
  assign gate_cmp_result = gate_cmp_valid && held_verdict;
  assign busy            = (state != IDLE);

  verdict_fifo #(
    .DEPTH (DEPTH)
  ) u_fifo (
    .clock     (clock),
    .reset     (reset),
    .push      (verdict_push),
    .push_data (verdict_result),
    .pop       (fifo_pop),
    .pop_data  (fifo_head),
    .full      (fifo_full),
    .empty     (fifo_empty)
  );

  // Next-state and per-cycle event decode for the issue/packet sequencer.
  always_comb begin
    state_next  = state;
    load_held   = 1'b0;
    fifo_pop    = 1'b0;
    pkt_done    = 1'b0;
    pkt_timeout = 1'b0;
    unique case (state)
      IDLE: begin
        if (!fifo_empty) begin
          load_held  = 1'b1;
          state_next = ISSUE;
        end
      end
      ISSUE: begin
        if (gate_cmp_ready) begin
          fifo_pop   = 1'b1;
          state_next = IN_PKT;
        end
      end
      IN_PKT: begin
        if (last_hs) begin
          pkt_done   = 1'b1;
          state_next = IDLE;
        end else if (TIMEOUT_EN && (timer == TIMER_LAST)) begin
          pkt_timeout = 1'b1;
          state_next  = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  // State register and the one-shot arming of verdict_ready.
  always_ff @(posedge clock) begin
    if (reset) begin
      state       <= IDLE;
      ready_armed <= 1'b0;
    end else begin
      state       <= state_next;
      ready_armed <= 1'b1;
    end
  end

  // Verdict held on the gate interface, and the verdict owning the current packet.
  always_ff @(posedge clock) begin
    if (load_held) held_verdict <= fifo_head;
    if (fifo_pop)  pkt_verdict  <= held_verdict;
  end

  // Packet age timer: cleared on issue handshake, counts every cycle in IN_PKT.
  always_ff @(posedge clock) begin
    if (reset) begin
      timer <= '0;
    end else if (fifo_pop) begin
      timer <= '0;
    end else if (TIMEOUT_EN && (state == IN_PKT)) begin
      timer <= timer + 1'b1;
    end
  end

  // Saturating statistics and sticky error flags; clear_stats overrides any update.
  always_ff @(posedge clock) begin
    if (reset || clear_stats) begin
      stat_pass   <= '0;
      stat_fail   <= '0;
      err_orphan  <= 1'b0;
      err_timeout <= 1'b0;
    end else begin
      if (pkt_done && (pkt_verdict == VERDICT_MATCH))    stat_pass <= sat_inc(stat_pass);
      if (pkt_done && (pkt_verdict == VERDICT_MISMATCH)) stat_fail <= sat_inc(stat_fail);
      if (pkt_timeout)                                   err_timeout <= 1'b1;
      if (beat_hs && (state != IN_PKT))                  err_orphan  <= 1'b1;
    end
  end

endmodule
